wash_cycle_sequencer: RTL
=========================

# wash_cycle_sequencer

Top-level stage controller for the washing-machine control system. It is the initiator side of the stage `Start`/done handshake. It sequences fill, wash, drain, rinse and spin by holding each stage module's start level high until that module reports done. It also drives the water valves and door lock, and enforces per-state timeouts and door interlock faults.

## Interface
- `FILL_LIMIT`, 16'd500: maximum cycles in FILL before fault.
- `DRAIN_LIMIT`, 16'd500: maximum cycles in DRAIN before fault.
- `STAGE_LIMIT`, 16'd2000: maximum cycles in WASH/RINSE/SPIN before fault.
- `RINSE_COUNT`, 2: rinse passes per cycle, 1..3.
- `CLK` input 1: sole clock; all logic on posedge.
- `RST` input 1: synchronous, active-high reset.
- `StartBtn` input 1: user start request (level; sampled in IDLE only).
- `DoorClosed` input 1: door sensor, 1 = closed.
- `WaterFull` input 1: level sensor, tub full.
- `WaterEmpty` input 1: level sensor, tub empty.
- `T1d`, `T2d`, `T3d` input 1 each: wash, rinse and spin done from the stage modules.
- `StartWash`, `StartRinse`, `StartSpin` output 1 each: stage start levels. Stage modules clear while low.
- `FillValve`, `DrainValve` output 1 each: valve drives.
- `DoorLock` output 1: door lock solenoid.
- `CycleDone` output 1: cycle complete indicator.
- `Fault` output 1: fault indicator.
- `RinsePass` output 2: rinse passes completed.
- `State` output 3: current state encoding.

## Operation
- State encodings: IDLE=0, FILL=1, WASH=2, DRAIN=3, RINSE=4, SPIN=5, DONE=6, FAULT=7.
- Moore outputs: each output is a decode of the state register only.
  - FILL: FillValve=1.
  - WASH: StartWash=1.
  - RINSE: StartRinse=1.
  - DRAIN: DrainValve=1.
  - SPIN: StartSpin=1 and DrainValve=1.
  - DONE: CycleDone=1.
  - FAULT: Fault=1 and DrainValve=1.
  - DoorLock=1 in every state except IDLE and DONE.
  - All other outputs are 0.
- `phase` flag: 0 = wash phase, 1 = rinse phase.
- `RinsePass` counter: 2 bits.
- Transitions:
  - IDLE → FILL: when StartBtn && DoorClosed. On this transition phase=0 and RinsePass=0.
  - FILL → WASH if WaterFull and phase=0.
  - FILL → RINSE if WaterFull and phase=1.
  - WASH → DRAIN on T1d.
  - RINSE → DRAIN on T2d. On this transition RinsePass increments.
  - DRAIN → (on WaterEmpty):
    - FILL with phase←1, if phase=0;
    - FILL, if phase=1 and RinsePass<RINSE_COUNT;
    - SPIN, otherwise.
  - SPIN → DONE on T3d.
  - DONE → IDLE when DoorClosed=0.
  - FAULT: absorbing; left only by RST.
- Per-state timer (16 bit):
  - Cleared on every state change.
  - Increments each cycle the state is unchanged, in FILL, WASH, DRAIN, RINSE and SPIN.
  - Saturates; it never wraps.
- Priority each cycle in active states (FILL..SPIN):
  1. DoorClosed=0 → FAULT.
  2. Exit condition true → normal transition.
  3. Timer == limit → FAULT.
  4. Otherwise stay.
- Done inputs are honoured only in their own stage state. Stale done levels in other states are ignored.
- StartBtn outside IDLE is ignored.

## Timing
- Reset: the next posedge with RST=1 sets:
  - State=IDLE;
  - all outputs 0, including DoorLock=0 and RinsePass=0;
  - timer=0 and phase=0.
- RST mid-operation drops any stage start on that edge. The aborted stage module clears itself.
- Transition latency: a condition sampled true at edge n sets the new state and outputs at edge n. They are visible after edge n.
- Start/done handshake:
  - The stage start rises on entry to the stage state.
  - It falls on the edge that samples done=1.
  - The following state never reasserts the same start. There is at least one DRAIN state between consecutive stages, so the start is low for at least one cycle before reuse.
- Maximum residency in a timed state is limit+1 cycles. A done or sensor input arriving on the limit cycle wins over the timeout.
- RinsePass increments on the RINSE→DRAIN edge. It holds through DONE and clears only on IDLE→FILL or RST.

## Test plan
- Full cycle with RINSE_COUNT=2:
  - Stimulus: StartBtn with door closed; WaterFull 5 cycles after each FILL entry; T1d, T2d and T3d after 10 cycles; WaterEmpty after 3 cycles.
  - Required state sequence: 0→1→2→3→1→4→3→1→4→3→5→6.
  - Required RinsePass 0→1→2. CycleDone=1, DoorLock=0 in DONE. Opening the door returns State=0.
- Fill timeout:
  - Stimulus: FILL_LIMIT=8, WaterFull never asserted.
  - Required: State=7 exactly 9 cycles after FILL entry; Fault=1, DrainValve=1, FillValve=0.
- Door interlock:
  - Stimulus: DoorClosed→0 during WASH.
  - Required: next edge State=7, StartWash=0, DoorLock=1. Later RST gives State=0 and all outputs 0.
- Timeout tie:
  - Stimulus: STAGE_LIMIT=10; T2d asserted on the cycle where the timer is 10.
  - Required: State=3 (DRAIN), not 7.
- Reset mid-rinse:
  - Stimulus: RST pulsed for 1 cycle in RINSE.
  - Required: StartRinse=0, RinsePass=0, State=0 after the edge. A stale T2d=1 afterwards is ignored.
- Ignored start:
  - Stimulus: StartBtn with DoorClosed=0.
  - Required: State stays 0. A StartBtn pulse during SPIN causes no change.

Source files
------------

// File: rtl/wash_cycle_sequencer_if.sv
// Sensor, stage-handshake and actuator bundle between the wash cycle
// sequencer (master) and the machine it controls (slave).
interface wash_cycle_sequencer_if;
    logic       StartBtn;
    logic       DoorClosed;
    logic       WaterFull;
    logic       WaterEmpty;
    logic       T1d;
    logic       T2d;
    logic       T3d;
    logic       StartWash;
    logic       StartRinse;
    logic       StartSpin;
    logic       FillValve;
    logic       DrainValve;
    logic       DoorLock;
    logic       CycleDone;
    logic       Fault;
    logic [1:0] RinsePass;
    logic [2:0] State;

    modport master (
        input  StartBtn, DoorClosed, WaterFull, WaterEmpty, T1d, T2d, T3d,
        output StartWash, StartRinse, StartSpin, FillValve, DrainValve,
               DoorLock, CycleDone, Fault, RinsePass, State
    );

    modport slave (
        output StartBtn, DoorClosed, WaterFull, WaterEmpty, T1d, T2d, T3d,
        input  StartWash, StartRinse, StartSpin, FillValve, DrainValve,
               DoorLock, CycleDone, Fault, RinsePass, State
    );
endinterface

// File: rtl/wash_cycle_sequencer.sv
// Washing-machine stage sequencer: fill, wash, drain, rinse passes, spin.
// Holds each stage start high until its done arrives, times every active
// state and drops into an absorbing FAULT on door-open or timeout.
module wash_cycle_sequencer #(
    parameter logic [15:0] FILL_LIMIT  = 16'd500,
    parameter logic [15:0] DRAIN_LIMIT = 16'd500,
    parameter logic [15:0] STAGE_LIMIT = 16'd2000,
    parameter int unsigned RINSE_COUNT = 2
) (
    input logic                     CLK,
    input logic                     RST,
    wash_cycle_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_DRAIN = 3'd3,
        S_RINSE = 3'd4,
        S_SPIN  = 3'd5,
        S_DONE  = 3'd6,
        S_FAULT = 3'd7
    } state_t;

    localparam logic [1:0] RINSE_CNT = 2'(RINSE_COUNT);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        phase_q, phase_d;
    logic [1:0]  rpass_q, rpass_d;
    logic [7:0]  outs_q;
    logic [15:0] limit_s;
    logic        timeout_s;
    logic        active_s;

    // Output decode, bit order:
    // {StartWash, StartRinse, StartSpin, FillValve, DrainValve, DoorLock, CycleDone, Fault}
    function automatic logic [7:0] decode_outputs(input state_t st);
        logic [7:0] o;
        case (st)
            S_IDLE:  o = 8'b0000_0000;
            S_FILL:  o = 8'b0001_0100;
            S_WASH:  o = 8'b1000_0100;
            S_DRAIN: o = 8'b0000_1100;
            S_RINSE: o = 8'b0100_0100;
            S_SPIN:  o = 8'b0010_1100;
            S_DONE:  o = 8'b0000_0010;
            S_FAULT: o = 8'b0000_1101;
            default: o = 8'b0000_1101;
        endcase
        return o;
    endfunction

    // Timeout limit that applies to the current state.
    always_comb begin
        limit_s = STAGE_LIMIT;
        case (state_q)
            S_FILL:  limit_s = FILL_LIMIT;
            S_DRAIN: limit_s = DRAIN_LIMIT;
            default: limit_s = STAGE_LIMIT;
        endcase
    end

    assign timeout_s = (timer_q == limit_s);
    assign active_s  = (state_q == S_FILL)  || (state_q == S_WASH) ||
                       (state_q == S_DRAIN) || (state_q == S_RINSE) ||
                       (state_q == S_SPIN);

    // Next state, phase and rinse counter; door, then exit, then timeout.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rpass_d = rpass_q;
        case (state_q)
            S_IDLE: begin
                if (bus.StartBtn && bus.DoorClosed) begin
                    state_d = S_FILL;
                    phase_d = 1'b0;
                    rpass_d = 2'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                if (!bus.DoorClosed) begin
                    state_d = S_FAULT;
                end else if (bus.WaterFull) begin
                    state_d = phase_q ? S_RINSE : S_WASH;
                end else if (timeout_s) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_WASH: begin
                if (!bus.DoorClosed) begin
                    state_d = S_FAULT;
                end else if (bus.T1d) begin
                    state_d = S_DRAIN;
                end else if (timeout_s) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_WASH;
                end
            end
            S_RINSE: begin
                if (!bus.DoorClosed) begin
                    state_d = S_FAULT;
                end else if (bus.T2d) begin
                    state_d = S_DRAIN;
                    rpass_d = rpass_q + 2'd1;
                end else if (timeout_s) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_RINSE;
                end
            end
            S_DRAIN: begin
                if (!bus.DoorClosed) begin
                    state_d = S_FAULT;
                end else if (bus.WaterEmpty) begin
                    if (!phase_q) begin
                        state_d = S_FILL;
                        phase_d = 1'b1;
                    end else if (rpass_q < RINSE_CNT) begin
                        state_d = S_FILL;
                    end else begin
                        state_d = S_SPIN;
                    end
                end else if (timeout_s) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_SPIN: begin
                if (!bus.DoorClosed) begin
                    state_d = S_FAULT;
                end else if (bus.T3d) begin
                    state_d = S_DONE;
                end else if (timeout_s) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_SPIN;
                end
            end
            S_DONE: begin
                if (!bus.DoorClosed) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    // Residency timer: cleared on any state change, saturating count otherwise.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = 16'd0;
        end else if (active_s && (timer_q != 16'hFFFF)) begin
            timer_d = timer_q + 16'd1;
        end else begin
            timer_d = timer_q;
        end
    end

    // State, bookkeeping and registered Moore outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            timer_q <= 16'd0;
            phase_q <= 1'b0;
            rpass_q <= 2'd0;
            outs_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            phase_q <= phase_d;
            rpass_q <= rpass_d;
            outs_q  <= decode_outputs(state_d);
        end
    end

    assign bus.StartWash  = outs_q[7];
    assign bus.StartRinse = outs_q[6];
    assign bus.StartSpin  = outs_q[5];
    assign bus.FillValve  = outs_q[4];
    assign bus.DrainValve = outs_q[3];
    assign bus.DoorLock   = outs_q[2];
    assign bus.CycleDone  = outs_q[1];
    assign bus.Fault      = outs_q[0];
    assign bus.RinsePass  = rpass_q;
    assign bus.State      = state_q;

endmodule
